// File: rtl/mips_multicycle_maindec_if.sv
// mips_multicycle_maindec_if: control bundle between the main decoder and the multicycle datapath
// master: decoder side (drives controls, reads op/zero); slave: datapath side.
interface mips_multicycle_maindec_if;
    logic [5:0] op;
    logic       zero;
    logic [3:0] aluop;
    logic       pcen;
    logic       irwrite;
    logic       iord;
    logic       memwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       zeroext;
    logic [1:0] pcsrc;
    logic       illegal;
    modport master (
        input  op, zero,
        output aluop, pcen, irwrite, iord, memwrite, regwrite, regdst,
               memtoreg, alusrca, alusrcb, zeroext, pcsrc, illegal
    );
    modport slave (
        output op, zero,
        input  aluop, pcen, irwrite, iord, memwrite, regwrite, regdst,
               memtoreg, alusrca, alusrcb, zeroext, pcsrc, illegal
    );
endinterface

// File: rtl/mips_multicycle_maindec.sv
// mips_multicycle_maindec: multicycle MIPS main controller FSM
// Ports: clk, reset (sync, active-high), ctl (master modport: op/zero in, datapath controls out).
module mips_multicycle_maindec (
    input  logic                       clk,
    input  logic                       reset,
    mips_multicycle_maindec_if.master  ctl
);
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLT = 4'd2, ALU_AND = 4'd4,
                           ALU_OR = 4'd5, ALU_XOR = 4'd6, ALU_LUI = 4'd7, ALU_FUNCT = 4'd15;
    localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_BEQ = 6'b000100,
                           OP_BNE = 6'b000101, OP_ADDI = 6'b001000, OP_ADDIU = 6'b001001,
                           OP_SLTI = 6'b001010, OP_ANDI = 6'b001100, OP_ORI = 6'b001101,
                           OP_XORI = 6'b001110, OP_LUI = 6'b001111, OP_LW = 6'b100011,
                           OP_SW = 6'b101011;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        RTYPEEX, RTYPEWB, BRANCHEX, IMMEX, IMMWB, JEX
    } state_t;

    typedef struct packed {
        logic       irwrite;
        logic       pcwrite;
        logic       branch;
        logic       iord;
        logic       memwrite;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       zeroext;
        logic [1:0] pcsrc;
        logic [3:0] aluop;
    } ctrl_t;

    state_t     state, ns;
    ctrl_t      ctrl;
    logic [3:0] imm_aluop, next_imm_aluop;
    logic       bne_sel, next_bne_sel, bad_op, live;

    function automatic logic [3:0] imm_alu(input logic [5:0] o);
        return (o == OP_SLTI) ? ALU_SLT :
               (o == OP_ANDI) ? ALU_AND :
               (o == OP_ORI)  ? ALU_OR  :
               (o == OP_XORI) ? ALU_XOR :
               (o == OP_LUI)  ? ALU_LUI : ALU_ADD;
    endfunction

    // Moore controls for a state; IMMEX additionally needs the latched immediate ALU op.
    function automatic ctrl_t ctrl_of(input state_t s, input logic [3:0] ia);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH:    begin c.irwrite = 1'b1; c.pcwrite = 1'b1; c.alusrcb = 2'b01; end
            DECODE:   c.alusrcb = 2'b11;
            MEMADR:   begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            MEMRD:    c.iord = 1'b1;
            MEMWB:    begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
            MEMWR:    begin c.iord = 1'b1; c.memwrite = 1'b1; end
            RTYPEEX:  begin c.alusrca = 1'b1; c.aluop = ALU_FUNCT; end
            RTYPEWB:  begin c.regdst = 1'b1; c.regwrite = 1'b1; end
            BRANCHEX: begin c.alusrca = 1'b1; c.aluop = ALU_SUB; c.pcsrc = 2'b01; c.branch = 1'b1; end
            IMMEX:    begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
                c.aluop   = ia;
                c.zeroext = (ia == ALU_AND) || (ia == ALU_OR) || (ia == ALU_XOR);
            end
            IMMWB:    c.regwrite = 1'b1;
            JEX:      begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
            default:  ;
        endcase
        return c;
    endfunction

    always_comb begin
        ns             = FETCH;
        next_imm_aluop = imm_aluop;
        next_bne_sel   = bne_sel;
        bad_op         = 1'b0;
        case (state)
            FETCH:   ns = DECODE;
            DECODE:  begin
                next_imm_aluop = imm_alu(ctl.op);
                next_bne_sel   = ctl.op == OP_BNE;
                case (ctl.op)
                    OP_LW, OP_SW:   ns = MEMADR;
                    OP_R:           ns = RTYPEEX;
                    OP_BEQ, OP_BNE: ns = BRANCHEX;
                    OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI,
                    OP_ORI, OP_XORI, OP_LUI: ns = IMMEX;
                    OP_J:           ns = JEX;
                    default:        bad_op = 1'b1;
                endcase
            end
            MEMADR:  ns = (ctl.op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   ns = MEMWB;
            RTYPEEX: ns = RTYPEWB;
            IMMEX:   ns = IMMWB;
            default: ns = FETCH;
        endcase
    end

    // Controls are registered for the state being entered, so they are valid from the cycle start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH;
            imm_aluop <= ALU_ADD;
            bne_sel   <= 1'b0;
            ctrl      <= ctrl_of(FETCH, ALU_ADD);
        end else begin
            state     <= ns;
            imm_aluop <= next_imm_aluop;
            bne_sel   <= next_bne_sel;
            ctrl      <= ctrl_of(ns, next_imm_aluop);
        end
    end

    // Enables are killed combinationally by reset (abandons the instruction in the same cycle)
    // and in any unused state encoding.
    assign live         = !reset && (state <= JEX);
    assign ctl.irwrite  = live & ctrl.irwrite;
    assign ctl.memwrite = live & ctrl.memwrite;
    assign ctl.regwrite = live & ctrl.regwrite;
    assign ctl.pcen     = live & (ctrl.pcwrite | (ctrl.branch & (ctl.zero ^ bne_sel)));
    assign ctl.illegal  = live & bad_op;
    assign ctl.iord     = ctrl.iord;
    assign ctl.regdst   = ctrl.regdst;
    assign ctl.memtoreg = ctrl.memtoreg;
    assign ctl.alusrca  = ctrl.alusrca;
    assign ctl.alusrcb  = ctrl.alusrcb;
    assign ctl.zeroext  = ctrl.zeroext;
    assign ctl.pcsrc    = ctrl.pcsrc;
    assign ctl.aluop    = ctrl.aluop;
endmodule

// File: doc/mips_multicycle_maindec.md
Name: mips_multicycle_maindec

Overview:
- Multicycle MIPS main controller FSM.
- Decodes the 6-bit opcode and sequences each instruction through fetch, decode, execute, memory and writeback cycles.
- Produces datapath enables, mux selects and the 4-bit alu_t aluop consumed by aludec; it is the producing end of the aluop interface.
- Sits in the controller alongside aludec and drives the shared instruction/data memory, the register file and the PC.

Parameters:
- None. All encodings come from mipspkg.sv.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
op  input  6  opcode, IR[31:26]; stable from the cycle after FETCH until the next FETCH
zero  input  1  ALU zero flag
aluop  output  4  alu_t: ADD=0, SUB=1, SLT=2, AND=4, OR=5, XOR=6, LUI=7, FUNCT=15
pcen  output  1  PC write enable = pcwrite | (branch & (zero ^ bne_sel))
irwrite  output  1  instruction register load
iord  output  1  memory address select: 0=PC, 1=ALUOut
memwrite  output  1  data memory write
regwrite  output  1  register file write
regdst  output  1  destination select: 0=rt, 1=rd
memtoreg  output  1  writeback select: 0=ALUOut, 1=memory data
alusrca  output  1  ALU A select: 0=PC, 1=regA
alusrcb  output  2  ALU B select: 00=regB, 01=const 4, 10=extended imm, 11=imm<<2
zeroext  output  1  immediate extension: 1=zero-extend, 0=sign-extend
pcsrc  output  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target
illegal  output  1  unrecognised opcode, asserted in DECODE

Behaviour:
- Encoding and timing:
  - Moore FSM; outputs depend on state and the latched imm_aluop/bne_sel only. pcen additionally depends combinationally on zero.
  - Any output not listed for a state is 0; aluop defaults to ADD.
- Reset:
  - reset high at a clock edge forces state to FETCH, imm_aluop to ADD and bne_sel to 0.
  - While reset is high, all enables are 0: irwrite, pcen, memwrite, regwrite, illegal.
  - Reset mid-instruction abandons that instruction with no write.
  - The first FETCH occurs in the cycle after reset deasserts.
- States and outputs:
  - FETCH: iord=0, irwrite=1, alusrca=0, alusrcb=01, aluop=ADD, pcsrc=00, pcwrite=1. Next state DECODE.
  - DECODE: alusrca=0, alusrcb=11, aluop=ADD. Latches imm_aluop and bne_sel from op.
    - Next state by op:
      - lw (100011) or sw (101011) -> MEMADR
      - R-type (000000) -> RTYPEEX
      - beq (000100) or bne (000101) -> BRANCHEX
      - addi (001000), addiu (001001), slti (001010), andi (001100), ori (001101), xori (001110), lui (001111) -> IMMEX
      - j (000010) -> JEX
      - anything else -> illegal=1, next state FETCH
  - MEMADR: alusrca=1, alusrcb=10, zeroext=0, aluop=ADD. Next MEMRD for lw, MEMWR for sw.
  - MEMRD: iord=1. Next MEMWB.
  - MEMWB: regdst=0, memtoreg=1, regwrite=1. Next FETCH.
  - MEMWR: iord=1, memwrite=1. Next FETCH.
  - RTYPEEX: alusrca=1, alusrcb=00, aluop=FUNCT. Next RTYPEWB.
  - RTYPEWB: regdst=1, memtoreg=0, regwrite=1. Next FETCH.
  - BRANCHEX: alusrca=1, alusrcb=00, aluop=SUB, pcsrc=01, branch=1.
    - pcen = zero for beq, ~zero for bne.
    - Next FETCH.
  - IMMEX: alusrca=1, alusrcb=10, aluop=imm_aluop. Next IMMWB.
    - imm_aluop: addi/addiu -> ADD; slti -> SLT; andi -> AND; ori -> OR; xori -> XOR; lui -> LUI.
    - zeroext=1 for andi/ori/xori; 0 otherwise.
  - IMMWB: regdst=0, memtoreg=0, regwrite=1. Next FETCH.
  - JEX: pcsrc=10, pcwrite=1. Next FETCH.
- Instruction lengths, FETCH to FETCH:
  - lw: 5 cycles
  - sw, R-type, immediate ops: 4 cycles
  - beq, bne, j: 3 cycles
  - illegal: 2 cycles
- Invariants:
  - memwrite and regwrite are never both 1.
  - irwrite=1 only in FETCH.
  - Unreachable state encodings return to FETCH on the next edge with all enables 0.

Test Plan:
- reset held 3 cycles, then op=100011 (lw) -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH; regwrite=1 and memtoreg=1 only in cycle 5; irwrite=1 only in cycle 1.
- op=000000 (R-type) -> aluop=15 in cycle 3; regwrite=1 and regdst=1 in cycle 4; back in FETCH at cycle 5.
- op=000100 (beq): zero=1 in BRANCHEX -> pcen=1, pcsrc=01. Repeat with zero=0 -> pcen=0. op=000101 (bne) with zero=0 -> pcen=1.
- op=001100 (andi) -> IMMEX aluop=4, zeroext=1. op=001111 (lui) -> aluop=7, zeroext=0. op=001010 (slti) -> aluop=2. Each has regwrite=1, regdst=0 in IMMWB.
- op=000010 (j) -> pcen=1, pcsrc=10 in cycle 3. op=111111 -> illegal=1 in DECODE, then FETCH, no memwrite/regwrite.
- reset asserted during MEMWR of sw -> memwrite=0 that cycle; FETCH the cycle after reset deasserts.
